edge2en_multi: RTL and testbench
================================

Name: edge2en_multi

Overview:
Multi-channel edge-to-enable converter for asynchronous control inputs such as buttons, strobes and external sync lines. Each channel has a configurable synchronizer chain and a glitch/debounce filter. Each channel produces registered one-cycle rising/falling pulses, a mode-selected event pulse and a sticky event flag. The block sits between raw pins and the controller logic, which consumes single-cycle enables in the clk_in domain.

Parameters:
CH_NUM, 8, number of independent channels (>=1)
SYNC_STAGES, 2, synchronizer flops per channel (>=2)
FILTER_LEN, 4, consecutive cycles a new synchronized level must persist before acceptance (>=1; 1 = no filtering)
INIT_LEVEL, 1'b0, level loaded into synchronizer and filtered level at reset
CNT_WIDTH, 8, event counter width (used only with the optional feature)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  synchronous active-low reset
edge_in  input  CH_NUM  raw asynchronous inputs, bit i = channel i
mode_in  input  2  event select, all channels: 00 none, 01 rising, 10 falling, 11 both
flag_clr_in  input  CH_NUM  per-channel sticky flag clear, level-sensitive
level_out  output  CH_NUM  filtered, synchronized level
rising_out  output  CH_NUM  one-cycle pulse on accepted 0->1
falling_out  output  CH_NUM  one-cycle pulse on accepted 1->0
event_out  output  CH_NUM  rising_out/falling_out masked by mode_in
any_event_out  output  1  OR of event_out
flag_out  output  CH_NUM  sticky event flag

Behaviour:
- One clock domain (clk_in). Reset is synchronous and active-low: sampled only on the clk_in rising edge while rst_n_in=0.
- Reset values:
  - Synchronizer flops and level_out = INIT_LEVEL on every channel.
  - Filter counters = 0.
  - rising_out, falling_out, event_out, any_event_out, flag_out = 0.
  - Because everything loads INIT_LEVEL, no edge is reported after reset release.
- Synchronizer: edge_in[i] shifts through SYNC_STAGES flops; s[i] is the last stage.
- Filter, per channel (counter width $clog2(FILTER_LEN+1)):
  - s[i]==level_out[i]: counter <= 0.
  - Otherwise, counter < FILTER_LEN-1: counter increments.
  - Otherwise, counter == FILTER_LEN-1: level_out[i] <= s[i] and counter <= 0.
  - Any single-cycle return to the old level restarts the count. Pulses shorter than FILTER_LEN cycles at s[i] are discarded.
- Latency: a stable change on edge_in first captured at clock edge 1 appears on level_out and the pulse outputs at edge SYNC_STAGES+FILTER_LEN (defaults: edge 6).
- Pulses:
  - rising_out[i] and falling_out[i] are registered. Each asserts for exactly one cycle, coincident with the cycle level_out[i] takes its new value.
  - Never both at once on the same channel.
  - Minimum spacing between pulses on one channel is FILTER_LEN cycles.
- event_out[i] = (mode_in[0] & rising_out[i]) | (mode_in[1] & falling_out[i]), combinational from registered pulses and mode_in. any_event_out = |event_out.
- Mode change takes effect immediately. It does not retrigger, and it does not alter filter or level state.
- flag_out[i]:
  - Set on the cycle after event_out[i]=1; holds until cleared.
  - Cleared on the cycle after flag_clr_in[i]=1.
  - Set and clear in the same cycle: set wins, flag stays 1.
- Channels are fully independent. Simultaneous edges on several channels all produce pulses in the same cycle.
- Reset mid-operation: in-flight filter counts are discarded, pending pulses are suppressed and flags are cleared. The first event after reset release requires the full latency.

Optional Feature:
Macro EDGE2EN_MULTI_EVENT_CNT_EN.
- Defined:
  - Adds output cnt_out, width CH_NUM*CNT_WIDTH, slice i = channel i.
  - Per-channel counter increments by 1 on each event_out[i] and saturates at all-ones (no wrap).
  - Cleared to 0 by reset, and by flag_clr_in[i] on the next edge.
  - Event and clear in the same cycle: counter <= 1.
- Undefined: the port and the counters do not exist. All other behaviour is identical.

Test Plan:
1. Reset with edge_in=0, release; hold edge_in[0]=1 from edge 1 -> level_out[0]=1 and rising_out[0]=1 for exactly one cycle at edge 6 (defaults); no other outputs toggle.
2. edge_in[2] high-pulse of 3 cycles -> no level change, no pulses; pulse of 4 cycles -> rising_out[2] at edge 6, falling_out[2] 4 cycles later.
3. Bounce pattern 1,1,0,1,1,1,1 on channel 1 -> a single rising_out[1], 4 cycles after the last return to 1 reaches s[1].
4. mode_in=10, toggle channel 3 up then down -> event_out[3] only on the fall; any_event_out mirrors it; flag_out[3]=1 the next cycle; flag_clr_in[3] asserted the same cycle as a new event -> flag_out[3] stays 1.
5. All 8 channels rise together with mode_in=11 -> event_out=8'hFF for one cycle. Assert rst_n_in=0 mid-filter on another transition -> all outputs 0 next edge, no pulse after release.
6. (EDGE2EN_MULTI_EVENT_CNT_EN, CNT_WIDTH=2) 5 events on channel 0 -> cnt_out[1:0] = 1,2,3,3,3. Clear together with an event -> 1.

Source files
------------

// File: rtl/edge2en_multi.sv
// rtl/edge2en_multi.sv - multi-channel synchronizer, debounce filter and edge-to-enable converter
// Optional per-channel saturating event counters via EDGE2EN_MULTI_EVENT_CNT_EN.
module edge2en_multi #(
   parameter int   CH_NUM      = 8,
   parameter int   SYNC_STAGES = 2,
   parameter int   FILTER_LEN  = 4,
   parameter logic INIT_LEVEL  = 1'b0,
   parameter int   CNT_WIDTH   = 8
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic [CH_NUM-1:0]           edge_in,
   input  logic [1:0]                  mode_in,
   input  logic [CH_NUM-1:0]           flag_clr_in,
   output logic [CH_NUM-1:0]           level_out,
   output logic [CH_NUM-1:0]           rising_out,
   output logic [CH_NUM-1:0]           falling_out,
   output logic [CH_NUM-1:0]           event_out,
   output logic                        any_event_out,
   output logic [CH_NUM-1:0]           flag_out
`ifdef EDGE2EN_MULTI_EVENT_CNT_EN
   ,
   output logic [CH_NUM*CNT_WIDTH-1:0] cnt_out
`endif
);

   localparam int             FCW       = $clog2(FILTER_LEN + 1);
   localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILTER_LEN - 1);

   logic [CH_NUM-1:0] r_sync [SYNC_STAGES];
   logic [FCW-1:0]    r_fcnt [CH_NUM];
   logic [CH_NUM-1:0] r_level;
   logic [CH_NUM-1:0] r_rise;
   logic [CH_NUM-1:0] r_fall;
   logic [CH_NUM-1:0] r_flag;
   logic [CH_NUM-1:0] w_s;
   logic [CH_NUM-1:0] w_event;

   assign w_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync[s] <= {CH_NUM{INIT_LEVEL}};
         end
      end else begin
         r_sync[0] <= edge_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
         end
      end
   end

   // A new level is accepted only after FILTER_LEN consecutive samples differ
   // from the current one; the pulse registers update in that same edge.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_level <= {CH_NUM{INIT_LEVEL}};
         r_rise  <= '0;
         r_fall  <= '0;
         for (int i = 0; i < CH_NUM; i++) begin
            r_fcnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            r_rise[i] <= 1'b0;
            r_fall[i] <= 1'b0;
            if (w_s[i] == r_level[i]) begin
               r_fcnt[i] <= '0;
            end else if (r_fcnt[i] != FCNT_LAST) begin
               r_fcnt[i] <= r_fcnt[i] + 1'b1;
            end else begin
               r_fcnt[i]  <= '0;
               r_level[i] <= w_s[i];
               r_rise[i]  <= w_s[i];
               r_fall[i]  <= ~w_s[i];
            end
         end
      end
   end

   assign w_event = ({CH_NUM{mode_in[0]}} & r_rise) | ({CH_NUM{mode_in[1]}} & r_fall);

   // Set has priority over a simultaneous clear.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_flag <= '0;
      end else begin
         r_flag <= (r_flag & ~flag_clr_in) | w_event;
      end
   end

`ifdef EDGE2EN_MULTI_EVENT_CNT_EN
   logic [CNT_WIDTH-1:0] r_evcnt [CH_NUM];

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < CH_NUM; i++) begin
            r_evcnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            if (flag_clr_in[i]) begin
               r_evcnt[i] <= w_event[i] ? CNT_WIDTH'(1) : '0;
            end else if (w_event[i] && (r_evcnt[i] != {CNT_WIDTH{1'b1}})) begin
               r_evcnt[i] <= r_evcnt[i] + 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_cnt_out
      assign cnt_out[g*CNT_WIDTH +: CNT_WIDTH] = r_evcnt[g];
   end
`else
   // No event counters in this build.
`endif

   assign level_out     = r_level;
   assign rising_out    = r_rise;
   assign falling_out   = r_fall;
   assign event_out     = w_event;
   assign any_event_out = |w_event;
   assign flag_out      = r_flag;

endmodule

// File: tb/tb_edge2en_multi.sv
// tb/tb_edge2en_multi.sv - directed self-checking bench for edge2en_multi
module tb_edge2en_multi;

   logic       clk_in = 1'b0;
   logic       rst_n_in;
   logic [7:0] edge_in;
   logic [1:0] mode_in;
   logic [7:0] flag_clr_in;
   logic [7:0] level_out;
   logic [7:0] rising_out;
   logic [7:0] falling_out;
   logic [7:0] event_out;
   logic       any_event_out;
   logic [7:0] flag_out;
`ifdef EDGE2EN_MULTI_EVENT_CNT_EN
   logic [15:0] cnt_out;
`endif

   int checks = 0;
   int errors = 0;

   edge2en_multi #(
      .CH_NUM(8), .SYNC_STAGES(2), .FILTER_LEN(4), .INIT_LEVEL(1'b0), .CNT_WIDTH(2)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .edge_in(edge_in), .mode_in(mode_in),
      .flag_clr_in(flag_clr_in), .level_out(level_out), .rising_out(rising_out),
      .falling_out(falling_out), .event_out(event_out), .any_event_out(any_event_out),
      .flag_out(flag_out)
`ifdef EDGE2EN_MULTI_EVENT_CNT_EN
      , .cnt_out(cnt_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0; edge_in = '0; mode_in = 2'b00; flag_clr_in = '0;
      repeat (3) tick();
      checks++; if (level_out !== 8'h00) begin errors++; $display("FAIL reset_level got %h exp 00", level_out); end
      checks++; if (rising_out !== 8'h00) begin errors++; $display("FAIL reset_rising got %h exp 00", rising_out); end
      checks++; if (falling_out !== 8'h00) begin errors++; $display("FAIL reset_falling got %h exp 00", falling_out); end
      checks++; if (event_out !== 8'h00 || any_event_out !== 1'b0) begin
         errors++; $display("FAIL reset_event got %h/%b exp 00/0", event_out, any_event_out); end
      checks++; if (flag_out !== 8'h00) begin errors++; $display("FAIL reset_flag got %h exp 00", flag_out); end
      rst_n_in = 1'b1;
      repeat (2) tick();
      checks++; if (rising_out !== 8'h00 || falling_out !== 8'h00) begin
         errors++; $display("FAIL release_no_edge got %h/%h exp 00/00", rising_out, falling_out); end
   endtask

   task automatic test_single_rise();
      logic [7:0] exp;
      edge_in[0] = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp = (k == 6) ? 8'h01 : 8'h00;
         checks++; if (rising_out !== exp) begin errors++; $display("FAIL rise0_pulse k=%0d got %h exp %h", k, rising_out, exp); end
         exp = (k >= 6) ? 8'h01 : 8'h00;
         checks++; if (level_out !== exp) begin errors++; $display("FAIL rise0_level k=%0d got %h exp %h", k, level_out, exp); end
         checks++; if (falling_out !== 8'h00 || event_out !== 8'h00 || flag_out !== 8'h00 || any_event_out !== 1'b0) begin
            errors++; $display("FAIL rise0_quiet k=%0d got fall %h ev %h flag %h any %b exp all 0", k, falling_out, event_out, flag_out, any_event_out); end
      end
      edge_in[0] = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp = (k == 6) ? 8'h01 : 8'h00;
         checks++; if (falling_out !== exp) begin errors++; $display("FAIL fall0_pulse k=%0d got %h exp %h", k, falling_out, exp); end
         exp = (k >= 6) ? 8'h00 : 8'h01;
         checks++; if (level_out !== exp) begin errors++; $display("FAIL fall0_level k=%0d got %h exp %h", k, level_out, exp); end
      end
   endtask

   task automatic test_glitch_filter();
      logic [7:0] exp;
      for (int k = 1; k <= 12; k++) begin
         edge_in[2] = (k <= 3);
         tick();
         checks++; if (level_out !== 8'h00 || rising_out !== 8'h00 || falling_out !== 8'h00) begin
            errors++; $display("FAIL glitch3 k=%0d got lvl %h r %h f %h exp 00", k, level_out, rising_out, falling_out); end
      end
      for (int k = 1; k <= 14; k++) begin
         edge_in[2] = (k <= 4);
         tick();
         exp = (k == 6) ? 8'h04 : 8'h00;
         checks++; if (rising_out !== exp) begin errors++; $display("FAIL pulse4_rise k=%0d got %h exp %h", k, rising_out, exp); end
         exp = (k == 10) ? 8'h04 : 8'h00;
         checks++; if (falling_out !== exp) begin errors++; $display("FAIL pulse4_fall k=%0d got %h exp %h", k, falling_out, exp); end
         exp = (k >= 6 && k < 10) ? 8'h04 : 8'h00;
         checks++; if (level_out !== exp) begin errors++; $display("FAIL pulse4_level k=%0d got %h exp %h", k, level_out, exp); end
      end
   endtask

   task automatic test_bounce();
      logic [6:0] pat;
      logic [7:0] exp;
      pat = 7'b1111011;
      for (int k = 1; k <= 14; k++) begin
         edge_in[1] = (k <= 7) ? pat[k-1] : 1'b1;
         tick();
         exp = (k == 9) ? 8'h02 : 8'h00;
         checks++; if (rising_out !== exp || falling_out !== 8'h00) begin
            errors++; $display("FAIL bounce k=%0d got r %h f %h exp r %h f 00", k, rising_out, falling_out, exp); end
      end
      edge_in[1] = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_mode_flag();
      logic [7:0] exp;
      mode_in = 2'b10;
      edge_in[3] = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp = (k == 6) ? 8'h08 : 8'h00;
         checks++; if (rising_out !== exp) begin errors++; $display("FAIL m10_rise k=%0d got %h exp %h", k, rising_out, exp); end
         checks++; if (event_out !== 8'h00 || any_event_out !== 1'b0 || flag_out !== 8'h00) begin
            errors++; $display("FAIL m10_masked k=%0d got ev %h any %b flag %h exp 0", k, event_out, any_event_out, flag_out); end
      end
      edge_in[3] = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp = (k == 6) ? 8'h08 : 8'h00;
         checks++; if (event_out !== exp || any_event_out !== (k == 6)) begin
            errors++; $display("FAIL m10_fall_ev k=%0d got %h/%b exp %h", k, event_out, any_event_out, exp); end
         exp = (k >= 7) ? 8'h08 : 8'h00;
         checks++; if (flag_out !== exp) begin errors++; $display("FAIL m10_flag k=%0d got %h exp %h", k, flag_out, exp); end
      end
      flag_clr_in[3] = 1'b1;
      tick();
      flag_clr_in[3] = 1'b0;
      checks++; if (flag_out !== 8'h00) begin errors++; $display("FAIL flag_clear got %h exp 00", flag_out); end
      edge_in[3] = 1'b1;
      repeat (9) tick();
      checks++; if (flag_out !== 8'h00) begin errors++; $display("FAIL flag_no_rise got %h exp 00", flag_out); end
      edge_in[3] = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 6) begin
            checks++; if (event_out !== 8'h08) begin errors++; $display("FAIL setclr_event got %h exp 08", event_out); end
            flag_clr_in[3] = 1'b1;
         end
         if (k == 7) begin
            checks++; if (flag_out !== 8'h08) begin errors++; $display("FAIL set_wins got %h exp 08", flag_out); end
            flag_clr_in[3] = 1'b0;
         end
         if (k == 9) begin
            checks++; if (flag_out !== 8'h08) begin errors++; $display("FAIL set_hold got %h exp 08", flag_out); end
         end
      end
      flag_clr_in = 8'hFF;
      tick();
      flag_clr_in = 8'h00;
      tick();
   endtask

   task automatic test_all_channels();
      logic [7:0] exp;
      mode_in = 2'b11;
      edge_in = 8'hFF;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp = (k == 6) ? 8'hFF : 8'h00;
         checks++; if (event_out !== exp || any_event_out !== (k == 6) || rising_out !== exp) begin
            errors++; $display("FAIL all_rise k=%0d got ev %h any %b r %h exp %h", k, event_out, any_event_out, rising_out, exp); end
      end
      checks++; if (flag_out !== 8'hFF) begin errors++; $display("FAIL all_flag got %h exp ff", flag_out); end
      edge_in = 8'h00;
      repeat (4) tick();
      rst_n_in = 1'b0;
      tick();
      checks++; if (level_out !== 8'h00 || rising_out !== 8'h00 || falling_out !== 8'h00) begin
         errors++; $display("FAIL midrst_state got lvl %h r %h f %h exp 00", level_out, rising_out, falling_out); end
      checks++; if (event_out !== 8'h00 || any_event_out !== 1'b0 || flag_out !== 8'h00) begin
         errors++; $display("FAIL midrst_flags got ev %h any %b flag %h exp 0", event_out, any_event_out, flag_out); end
      rst_n_in = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++; if (rising_out !== 8'h00 || falling_out !== 8'h00 || level_out !== 8'h00) begin
            errors++; $display("FAIL post_rst k=%0d got r %h f %h lvl %h exp 00", k, rising_out, falling_out, level_out); end
      end
      edge_in[5] = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp = (k == 6) ? 8'h20 : 8'h00;
         checks++; if (rising_out !== exp) begin errors++; $display("FAIL post_rst_lat k=%0d got %h exp %h", k, rising_out, exp); end
      end
      edge_in = 8'h00;
      repeat (10) tick();
      flag_clr_in = 8'hFF;
      tick();
      flag_clr_in = 8'h00;
      tick();
   endtask

`ifdef EDGE2EN_MULTI_EVENT_CNT_EN
   task automatic test_event_cnt();
      logic [1:0] exp;
      mode_in = 2'b01;
      checks++; if (cnt_out !== 16'h0000) begin errors++; $display("FAIL cnt_start got %h exp 0000", cnt_out); end
      for (int e = 1; e <= 5; e++) begin
         exp = (e <= 3) ? 2'(e) : 2'd3;
         edge_in[0] = 1'b1;
         repeat (8) tick();
         checks++; if (cnt_out[1:0] !== exp) begin errors++; $display("FAIL cnt_ev%0d got %0d exp %0d", e, cnt_out[1:0], exp); end
         edge_in[0] = 1'b0;
         repeat (8) tick();
         checks++; if (cnt_out !== {14'h0, exp}) begin errors++; $display("FAIL cnt_hold%0d got %h exp %h", e, cnt_out, {14'h0, exp}); end
      end
      edge_in[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 6) flag_clr_in[0] = 1'b1;
         if (k == 7) begin
            checks++; if (cnt_out[1:0] !== 2'd1) begin errors++; $display("FAIL cnt_clr_ev got %0d exp 1", cnt_out[1:0]); end
            flag_clr_in[0] = 1'b0;
         end
      end
      edge_in[0] = 1'b0;
      repeat (8) tick();
      flag_clr_in[0] = 1'b1;
      tick();
      flag_clr_in[0] = 1'b0;
      checks++; if (cnt_out !== 16'h0000) begin errors++; $display("FAIL cnt_clr got %h exp 0000", cnt_out); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_rise();
      test_glitch_filter();
      test_bounce();
      test_mode_flag();
      test_all_channels();
`ifdef EDGE2EN_MULTI_EVENT_CNT_EN
      test_event_cnt();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
